serial_capture_shift_reg: RTL and testbench
===========================================

// Module: serial_capture_shift_reg
// PURPOSE
//  Parametrised serial-to-parallel capture block for gyro/sensor serial links.
//  - Samples an external shift clock (sclk) and data (sdi) in the system clk domain, framed by active-low frame_n.
//  - Assembles WIDTH-bit words and presents them on a valid/ready output.
//  - Successor to the fixed 32-bit negedge input shift register: adds configurable width, edge and bit order,
//    plus a bit counter, handshake, overrun and abort detection.
// PARAMETERS
//  WIDTH        32  word length in bits (>=2)
//  SAMPLE_EDGE  0   0 = sample sdi on sclk falling edge, 1 = rising edge
//  MSB_FIRST    1   1 = shift left, new bit enters LSB; 0 = shift right, new bit enters MSB
//  SYNC_STAGES  2   synchronizer depth for sclk/sdi/frame_n (>=2)
// PORTS
//  clk            in   1                    system clock, all logic on posedge
//  reset_n        in   1                    synchronous, active-low reset
//  sclk           in   1                    asynchronous external shift clock
//  sdi            in   1                    asynchronous serial data
//  frame_n        in   1                    asynchronous frame enable, active low
//  out_data       out  WIDTH                captured word, stable while out_valid=1
//  out_valid      out  1                    word available
//  out_ready      in   1                    consumer accepts word when out_valid & out_ready
//  bit_count      out  $clog2(WIDTH+1)      bits shifted into the current partial word
//  frame_abort    out  1                    one-clk pulse: frame ended with a partial word
//  overrun        out  1                    sticky: a completed word was dropped
//  clear_overrun  in   1                    clears overrun
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk posedge), applies mid-frame too:
//    out_data=0, out_valid=0, bit_count=0, frame_abort=0, overrun=0, shift reg=0,
//    sync chains=idle values (sclk=0, sdi=0, frame_n=1), state=IDLE.
//  - sclk, sdi and frame_n each pass through SYNC_STAGES flops.
//  - Sampling edge = synced sclk vs. its previous value, per SAMPLE_EDGE.
//    sdi is taken from the synced chain in the same cycle the edge is detected.
//  - Input timing: sclk high and low phases are each >= SYNC_STAGES+1 clk.
//    Faster sclk is unsupported; no detection is required.
//  - FSM IDLE/ACTIVE.
//    IDLE: edges ignored. Synced frame_n=0 -> ACTIVE, with bit_count=0 and shift reg=0.
//    ACTIVE: each sampling edge shifts 1 bit and increments bit_count.
//    When bit_count would reach WIDTH, the completed word goes to the output stage and bit_count returns to 0.
//    The FSM stays ACTIVE, so back-to-back words are allowed within one frame.
//    Synced frame_n=1 -> IDLE. If bit_count!=0, pulse frame_abort for 1 clk and discard the partial word.
//    A sampling edge in the same cycle as frame_n rising is ignored.
//  - Output stage:
//    Completion with out_valid=0 loads out_data and sets out_valid the next clk.
//    Latency from raw sclk edge to out_valid is SYNC_STAGES+2 clk.
//  - out_valid and out_data hold until out_valid & out_ready; out_valid then clears the next clk.
//  - Completion and acceptance in the same cycle: the new word loads and out_valid stays 1.
//  - Completion while out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged, overrun is set.
//  - clear_overrun clears overrun next clk. A simultaneous new overrun wins (overrun stays 1).
//  - bit_count never exceeds WIDTH-1 when observed.
// STRUCTURE
//  - Package gyro_serial_pkg:
//    typedef enum logic {EDGE_NEG, EDGE_POS} edge_e; typedef enum logic {S_IDLE, S_ACTIVE} cap_state_e.
//  - Sub-module serial_sync_edge (params SYNC_STAGES, EDGE): synchronizer plus edge-detect pulse.
//    Instantiated for sclk; plain sync chains for sdi and frame_n.
//  - Top level holds the FSM, shift register, bit counter and output/handshake stage.
// TESTING
//  1. reset_n=0 for 2 clk mid-stream -> out_valid=0, out_data=0, bit_count=0, overrun=0, frame_abort=0.
//  2. Defaults; frame_n=0; 32 bits of 0xA5C30F1E MSB first on falling sclk; out_ready=1
//     -> one out_valid pulse, out_data=0xA5C30F1E, bit_count=0.
//  3. MSB_FIRST=0, SAMPLE_EDGE=1; send 0x12345678 LSB first on rising sclk -> out_data=0x12345678.
//  4. out_ready=0; send 0x11111111 then 0x22222222 in one frame
//     -> out_data stays 0x11111111, overrun=1; assert clear_overrun -> overrun=0.
//  5. Stop after 13 bits and raise frame_n -> frame_abort high exactly 1 clk, out_valid stays 0.
//     Next full frame 0xDEADBEEF is captured correctly.
//  6. Completion on the same clk as acceptance with out_ready=1
//     -> out_valid stays 1 and out_data updates to the second word; no overrun.

Source files
------------

// File: rtl/serial_capture_shift_reg_pkg.sv
// Shared types for the gyro/sensor serial capture path.
package gyro_serial_pkg;

    typedef enum logic {EDGE_NEG, EDGE_POS} edge_e;
    typedef enum logic {S_IDLE, S_ACTIVE} cap_state_e;

endpackage

// File: rtl/serial_capture_shift_reg_if.sv
// Word output stream of the serial capture block: valid/ready with data held while valid.
interface serial_capture_shift_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/serial_capture_shift_reg_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a one-clk pulse on the selected edge.
module serial_sync_edge
    import gyro_serial_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter edge_e EDGE        = EDGE_NEG
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];

    // Edge is visible in the same cycle the new level leaves the chain.
    assign edge_pulse = (EDGE == EDGE_POS) ? ( dout & ~prev_q)
                                           : (~dout &  prev_q);

endmodule

// File: rtl/serial_capture_shift_reg.sv
// Serial-to-parallel capture: sync'd sclk/sdi/frame_n, IDLE/ACTIVE framing FSM,
// bit counter and a single-entry valid/ready output stage with overrun/abort status.
module serial_capture_shift_reg
    import gyro_serial_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SAMPLE_EDGE = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(WIDTH+1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  sdi,
    input  logic                  frame_n,
    serial_capture_shift_reg_if.master out_if,
    output logic [CW-1:0]         bit_count,
    output logic                  frame_abort,
    output logic                  overrun,
    input  logic                  clear_overrun
);

    localparam edge_e         EDGE_SEL = (SAMPLE_EDGE != 0) ? EDGE_POS : EDGE_NEG;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

    // ---------------- input synchronization
    logic                   sclk_s;
    logic                   samp;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] frame_sync_q;
    logic                   sdi_s;
    logic                   frame_n_s;

    serial_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EDGE_SEL)
    ) u_sclk_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (sclk),
        .dout       (sclk_s),
        .edge_pulse (samp)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sdi_sync_q   <= '0;
            frame_sync_q <= '1;
        end else begin
            sdi_sync_q   <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], frame_n};
        end
    end

    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign frame_n_s = frame_sync_q[SYNC_STAGES-1];

    // ---------------- framing FSM + shifter
    cap_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    assign shifted = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], sdi_s}
                                      : {sdi_s, shift_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!frame_n_s) begin
                    state_d = S_ACTIVE;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            S_ACTIVE: begin
                // Frame end takes priority over a coincident sampling edge.
                if (frame_n_s) begin
                    state_d = S_IDLE;
                    abort_d = (cnt_q != '0);
                    cnt_d   = '0;
                end else if (samp) begin
                    shift_d = shifted;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output stage
    // done_q marks a complete word sitting in shift_q; no new bit can arrive
    // before the next sclk phase, so loading from shift_q a cycle later is safe.
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ovr_q;
    logic             accept;

    assign accept = valid_q & out_if.out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (done_q && (!valid_q || accept)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end

            if (done_q && valid_q && !accept)
                ovr_q <= 1'b1;
            else if (clear_overrun)
                ovr_q <= 1'b0;
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign bit_count        = cnt_q;
    assign frame_abort      = abort_q;
    assign overrun          = ovr_q;

    logic unused_ok;
    assign unused_ok = sclk_s;

endmodule

// File: tb/tb_serial_capture_shift_reg.sv
// Scoreboard bench: two captures (default MSB-first/falling, and LSB-first/rising).
module tb_serial_capture_shift_reg;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int N  = 4;   // clk per sclk phase, >= SS+1

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sclk0, sdi0, frm0, clr0;
    logic       sclk1, sdi1, frm1, clr1;
    logic [5:0] bc0, bc1;
    logic       ab0, ab1, ov0, ov1;

    int          checks = 0;
    int          errors = 0;
    int          acc0 = 0, acc1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp0, exp1;

    always #5 clk = ~clk;

    serial_capture_shift_reg_if #(.WIDTH(W)) if0 ();
    serial_capture_shift_reg_if #(.WIDTH(W)) if1 ();

    serial_capture_shift_reg #(.WIDTH(W), .SAMPLE_EDGE(0), .MSB_FIRST(1), .SYNC_STAGES(SS)) dut0 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk0), .sdi(sdi0), .frame_n(frm0),
        .out_if(if0), .bit_count(bc0), .frame_abort(ab0), .overrun(ov0), .clear_overrun(clr0)
    );

    serial_capture_shift_reg #(.WIDTH(W), .SAMPLE_EDGE(1), .MSB_FIRST(0), .SYNC_STAGES(SS)) dut1 (
        .clk(clk), .reset_n(reset_n), .sclk(sclk1), .sdi(sdi1), .frame_n(frm1),
        .out_if(if1), .bit_count(bc1), .frame_abort(ab1), .overrun(ov1), .clear_overrun(clr1)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // dut0 samples on falling sclk (idle low), dut1 on rising sclk.
    task automatic send_bits(input bit sel, input logic [31:0] w, input int nbits, input bit msb);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = msb ? w[31-i] : w[i];
            if (!sel) begin
                sclk0 = 1'b1; sdi0 = b; tick(N);
                sclk0 = 1'b0; tick(N);
            end else begin
                sclk1 = 1'b0; sdi1 = b; tick(N);
                sclk1 = 1'b1; tick(N);
            end
        end
        if (sel) begin
            sclk1 = 1'b0; tick(N);
        end
    endtask

    task automatic drain(input bit sel);
        int t = 0;
        while (((sel ? q1.size() : q0.size()) != 0) && t < 2000) begin
            tick(1);
            t++;
        end
        chk(sel ? "drain1" : "drain0", sel ? q1.size() : q0.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && if0.out_valid && if0.out_ready) begin
            acc0++;
            if (q0.size() == 0) chk("unexpected0", 1, 0);
            else begin
                exp0 = q0.pop_front();
                chk("data0", if0.out_data, exp0);
            end
        end
        if (reset_n && if1.out_valid && if1.out_ready) begin
            acc1++;
            if (q1.size() == 0) chk("unexpected1", 1, 0);
            else begin
                exp1 = q1.pop_front();
                chk("data1", if1.out_data, exp1);
            end
        end
    end

    initial begin
        int a, na, nv;
        logic [31:0] wb;
        reset_n = 1'b0;
        sclk0 = 0; sdi0 = 0; frm0 = 1; clr0 = 0;
        sclk1 = 0; sdi1 = 0; frm1 = 1; clr1 = 0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        tick(3);
        chk("rst_valid", if0.out_valid, 0);
        chk("rst_data", if0.out_data, 0);
        chk("rst_bc", bc0, 0);
        reset_n = 1'b1;
        tick(2);

        // 1: reset mid-frame
        frm0 = 1'b0; tick(N);
        send_bits(0, 32'hFFC0_0000, 10, 1);
        chk("bc_partial", bc0, 10);
        reset_n = 1'b0; tick(2);
        chk("mid_rst_valid", if0.out_valid, 0);
        chk("mid_rst_data", if0.out_data, 0);
        chk("mid_rst_bc", bc0, 0);
        chk("mid_rst_ovr", ov0, 0);
        chk("mid_rst_abort", ab0, 0);
        frm0 = 1'b1; reset_n = 1'b1; tick(N);

        // 2: default MSB-first capture
        frm0 = 1'b0; tick(N);
        a = acc0;
        q0.push_back(32'hA5C3_0F1E);
        send_bits(0, 32'hA5C3_0F1E, 32, 1);
        chk("bc_after_word", bc0, 0);
        frm0 = 1'b1; tick(N);
        drain(0);
        chk("one_pulse", acc0 - a, 1);

        // 3: LSB-first, rising edge
        frm1 = 1'b0; tick(N);
        q1.push_back(32'h1234_5678);
        send_bits(1, 32'h1234_5678, 32, 0);
        frm1 = 1'b1; tick(N);
        drain(1);
        chk("acc1", acc1, 1);

        // 4: overrun
        if0.out_ready = 1'b0;
        frm0 = 1'b0; tick(N);
        q0.push_back(32'h1111_1111);
        send_bits(0, 32'h1111_1111, 32, 1);
        send_bits(0, 32'h2222_2222, 32, 1);
        chk("ovr_valid", if0.out_valid, 1);
        chk("ovr_data", if0.out_data, 32'h1111_1111);
        chk("ovr_set", ov0, 1);
        frm0 = 1'b1; tick(N);
        clr0 = 1'b1; tick(1); clr0 = 1'b0;
        chk("ovr_clear", ov0, 0);
        if0.out_ready = 1'b1;
        drain(0);

        // 5: abort after 13 bits, then a clean frame
        frm0 = 1'b0; tick(N);
        send_bits(0, 32'h5A5A_5A5A, 13, 1);
        chk("bc13", bc0, 13);
        frm0 = 1'b1;
        na = 0; nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ab0) na++;
            if (if0.out_valid) nv++;
        end
        chk("abort_pulse", na, 1);
        chk("abort_novalid", nv, 0);
        tick(N);
        frm0 = 1'b0; tick(N);
        q0.push_back(32'hDEAD_BEEF);
        send_bits(0, 32'hDEAD_BEEF, 32, 1);
        frm0 = 1'b1; tick(N);
        drain(0);

        // 6: completion coincident with acceptance
        if0.out_ready = 1'b0;
        frm0 = 1'b0; tick(N);
        wb = 32'hCAFE_BABE;
        q0.push_back(32'h0BAD_F00D);
        q0.push_back(wb);
        send_bits(0, 32'h0BAD_F00D, 32, 1);
        chk("held_valid", if0.out_valid, 1);
        send_bits(0, wb, 31, 1);
        sdi0 = wb[0]; sclk0 = 1'b1; tick(N);
        sclk0 = 1'b0; tick(SS + 1);
        if0.out_ready = 1'b1; tick(1);
        if0.out_ready = 1'b0;
        chk("same_valid", if0.out_valid, 1);
        chk("same_data", if0.out_data, wb);
        chk("same_novr", ov0, 0);
        frm0 = 1'b1;
        if0.out_ready = 1'b1;
        drain(0);
        tick(4);
        chk("dut1_quiet_ovr", ov1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
